reg_bus_master: RTL

REG_BUS_MASTER -- requirements
Module: reg_bus_master

---
 rtl/reg_bus_pkg.sv | 31 +++
 rtl/reg_bus_cmd_fifo.sv | 54 +++++
 rtl/reg_bus_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reg_bus_pkg.sv
// Shared widths, FSM encodings and command packing for the register-bus master.
package reg_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic cmd_t cmd_pack(input logic rw, input logic [ADDR_W-1:0] addr,
                                    input logic [DATA_W-1:0] wdata);
    cmd_t c;
    c.rw    = rw;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/reg_bus_cmd_fifo.sv
// Command FIFO: power-of-two depth, extra pointer bit separates full from empty.
module reg_bus_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Full is judged on the registered pointers only, so a same-cycle pop never frees a slot.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer advance
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus master: queues commands and issues one-clock register accesses with
// read-latency wait, response hold and a forced idle gap after every access.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RD_LAT    = 1,
  parameter int GAP       = 1
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              cs,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [1:0] RD_CNT0  = 2'(RD_LAT - 1);
  localparam logic [1:0] GAP_CNT0 = 2'(GAP - 1);
  localparam state_e     AFTER_ACC = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_e            state_r, state_s;
  logic [1:0]        cnt_r, cnt_s;
  logic              cs_r, cs_s, rw_r, rw_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              pop_s, fifo_empty_s, fifo_full_s;
  cmd_t              head_s;

  reg_bus_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .xrst      (xrst),
    .push      (cmd_valid),
    .push_data (cmd_pack(cmd_rw, cmd_addr, cmd_wdata)),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign cmd_ready = !fifo_full_s;
  assign busy      = !fifo_empty_s || (state_r != ST_IDLE);
  assign cs        = cs_r;
  assign rw        = rw_r;
  assign addr      = addr_r;
  assign wdata     = wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

  // Next state and next register values; bus fields default to zero so cs lasts one clock.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cs_s        = 1'b0;
    rw_s        = 1'b0;
    addr_s      = {ADDR_W{1'b0}};
    wdata_s     = {DATA_W{1'b0}};
    rsp_valid_s = rsp_valid_r;
    rsp_rdata_s = rsp_rdata_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cs_s    = 1'b1;
          rw_s    = head_s.rw;
          addr_s  = head_s.addr;
          wdata_s = head_s.wdata;
          state_s = ST_ACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (rw_r) begin
          state_s = AFTER_ACC;
          cnt_s   = GAP_CNT0;
        end else begin
          state_s = ST_RWAIT;
          cnt_s   = RD_CNT0;
        end
      end
      ST_RWAIT: begin
        if (cnt_r == 2'd0) begin
          rsp_valid_s = 1'b1;
          rsp_rdata_s = rdata;
          state_s     = ST_RESP;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = AFTER_ACC;
          cnt_s       = GAP_CNT0;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_GAP: begin
        if (cnt_r == 2'd0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, bus and response registers
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      cs_r        <= 1'b0;
      rw_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cs_r        <= cs_s;
      rw_r        <= rw_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
    end
  end

endmodule
